alu_arbiter: RTL
================

# alu_arbiter

Sequencer and two-port arbiter for the shared 32-bit combinational ALU in the APCPU datapath. It accepts operation requests (A, B, ALU_Sel) from two requesters over valid/ready handshakes, grants one at a time, drives the ALU inputs for one execute cycle, and registers ALU_Out/CarryOut. It then returns the result to the granted requester over a valid/ready response channel. It sits between the ALU and its users, for example the integer pipe and the address-generation unit.

## Interface
- `DATA_W`, 32, operand/result width
- `SEL_W`, 8, ALU selection width; code 0 is NOP
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i
- `req_ready`  out  2  per-requester request accept
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_W each  operands
- `req0_sel` / `req1_sel`  in  SEL_W  ALU selection
- `rsp_valid`  out  2  per-requester response valid
- `rsp_ready`  in  2  per-requester response accept
- `rsp_data`  out  DATA_W  registered ALU result, shared by both response channels
- `rsp_carry`  out  1  registered CarryOut
- `alu_a`, `alu_b`  out  DATA_W  to ALU A/B
- `alu_sel`  out  SEL_W  to ALU_Sel
- `alu_out`  in  DATA_W  from ALU_Out
- `alu_carry`  in  1  from CarryOut
- `busy`  out  1  high in any state other than IDLE
- `grant_id`  out  1  requester currently owning the ALU
- `ops_done`  out  16  count of completed responses; wraps

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- **IDLE**
  - `req_ready` is combinational. Only the selected requester's bit is asserted, and only if its `req_valid` is high.
  - On valid&ready: latch a/b/sel into operand registers, latch `grant_id`, go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC** (exactly 1 cycle)
  - `alu_a`, `alu_b`, `alu_sel` are driven from the operand registers.
  - At cycle end, `alu_out` and `alu_carry` are captured into `rsp_data` and `rsp_carry`. Go to RESP.
- **RESP**
  - `rsp_valid[grant_id]` = 1. The other `rsp_valid` bit is 0.
  - Hold until `rsp_ready[grant_id]` is high. On that handshake: increment `ops_done` (16-bit, FFFF→0000), update the arbitration pointer, go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- **ALU driving outside EXEC:** `alu_sel` = 0 (NOP). `alu_a` and `alu_b` hold the operand registers.
- `req_ready` is 0 in EXEC and RESP. Requests arriving then wait; valid must stay asserted per handshake rules.
- **Simultaneous requests in IDLE:** resolved by the selection rule in Configuration.
- `rsp_data` and `rsp_carry` hold their values after the response is accepted, until the next EXEC capture.
- **Reset:**
  - Returns to IDLE from any state. A mid-operation request or response is dropped without handshake.
  - Reset values: `req_ready` = 0 during reset; `rsp_valid` = 0; `rsp_data` = 0; `rsp_carry` = 0; `alu_a` = `alu_b` = 0; `alu_sel` = 0; `busy` = 0; `grant_id` = 0; `ops_done` = 0; RR pointer = 0.

## Timing
- Request accepted at edge T. EXEC occupies cycle T+1; the result is captured at edge T+2. `rsp_valid` is high from cycle T+2.
- Minimum turnaround is 3 cycles per operation, reached with `rsp_ready` held high. A new request can be accepted in the cycle after the response handshake.
- `req_ready` depends combinationally on `req_valid` and the pointer. There is no combinational path from `rsp_ready` to `req_ready`.
- The ALU path is single-cycle combinational and must meet one `clk` period from `alu_a`/`alu_b`/`alu_sel` to `alu_out`/`alu_carry`.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin selection.
  - The pointer names the preferred requester.
  - After each completed response, the pointer moves to the requester not just served.
  - With both requesting, grants alternate 0,1,0,1.
- `ALU_ARB_RR_EN` undefined: fixed priority, with requester 0 always winning.
  - The pointer register is absent.
  - Requester 1 is granted only when `req_valid[0]` is 0 in IDLE.

## Test plan
- **Single op:** reset, then req0 with a=32'hFFFF_FFFF, b=1, sel=1 (bench ALU model: add) and `rsp_ready` held high. Required: `rsp_valid[0]` 2 cycles after accept, `rsp_data`=0, `rsp_carry`=1, `ops_done`=1.
- **Contention:** both requesters valid continuously for 4 ops each, with `ALU_ARB_RR_EN` defined. Required grants 0,1,0,1,…; each op takes 3 cycles; `ops_done`=8.
  - Same stimulus without the macro: four grants to 0 first, then four to 1.
- **Response backpressure:** `rsp_ready[1]` held low for 5 cycles during an op from req1. Required: `rsp_valid[1]` and `rsp_data` stable for those cycles; `req_ready` stays 0 for a pending req0; req0 is accepted the cycle after the handshake.
- **Bus quiet:** monitor `alu_sel` over random traffic. Required: nonzero only in EXEC cycles; `busy` matches non-IDLE states.
- **Reset mid-operation:** assert `rst_n`=0 during RESP. Required: next cycle has all outputs at reset values and `ops_done` unchanged from 0.
- **Counter wrap:** preload via 65536 ops (or force counter to 16'hFFFF) and complete one op. Required: `ops_done`=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester valid/ready sequencer for the shared single-cycle combinational ALU.
// Build option: define ALU_ARB_RR_EN for round-robin selection; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              busy,
  output logic              grant_id,
  output logic [15:0]       ops_done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q;
  logic [SEL_W-1:0]    op_sel_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_carry_q;
  logic [15:0]         ops_done_q, ops_done_d;
  logic                sel_id;
  logic                req_hs, rsp_hs;

  // Requester offered the ALU while IDLE; only meaningful when its valid is high.
`ifdef ALU_ARB_RR_EN
  logic rr_ptr_q;

  always_comb begin
    sel_id = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else if (rsp_hs) begin
      rr_ptr_q <= ~grant_q;
    end
  end
`else
  always_comb begin
    sel_id = ~req_valid[0];
  end
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holds valid and its payload stable until that edge, ready never waits on the
  // other side's ready, and rsp_ready of the requester that is not granted is ignored.
  always_comb begin
    state_d    = state_q;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    req_hs     = 1'b0;
    rsp_hs     = 1'b0;
    ops_done_d = ops_done_q;
    case (state_q)
      S_IDLE: begin
        if (rst_n && req_valid[sel_id]) begin
          req_ready[sel_id] = 1'b1;
          req_hs            = 1'b1;
          state_d           = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          rsp_hs     = 1'b1;
          ops_done_d = ops_done_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      ops_done_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        grant_q  <= sel_id;
        op_a_q   <= sel_id ? req1_a : req0_a;
        op_b_q   <= sel_id ? req1_b : req0_b;
        op_sel_q <= sel_id ? req1_sel : req0_sel;
      end
      // The ALU result is only trusted at the end of the single EXEC cycle.
      if (state_q == S_EXEC) begin
        rsp_data_q  <= alu_out;
        rsp_carry_q <= alu_carry;
      end
      if (rsp_hs) begin
        ops_done_q <= ops_done_d;
      end
    end
  end

  // Operands stay parked on the bus; only the select is forced to NOP outside EXEC.
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = (state_q == S_EXEC) ? op_sel_q : '0;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_q;
  assign ops_done  = ops_done_q;
  assign dbg_state = state_q;

endmodule
